// File: rtl/cart_mem_arbiter.sv
// Shares one external cart memory port between a PRG (CPU) and a CHR (PPU) access slot.
// Each slot holds one request; grants alternate round-robin with an idle cycle between requests.
module cart_mem_arbiter #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prg_read,
  input  logic          prg_write,
  input  logic [AW-1:0] prg_aout,
  input  logic [7:0]    prg_din,
  input  logic          prg_allow,
  input  logic          prg_bus_write,
  input  logic [7:0]    prg_mapper_dout,
  input  logic          chr_read,
  input  logic          chr_write,
  input  logic [AW-1:0] chr_aout,
  input  logic [7:0]    chr_din,
  input  logic          chr_allow,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    prg_dout,
  output logic [7:0]    chr_dout,
  output logic          prg_valid,
  output logic          chr_valid,
  output logic          prg_overrun,
  output logic          chr_overrun
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            prg_full_q, prg_full_d, chr_full_q, chr_full_d;
  logic            prg_we_q, prg_we_d, chr_we_q, chr_we_d;
  logic [AW-1:0]   prg_addr_q, prg_addr_d, chr_addr_q, chr_addr_d;
  logic [7:0]      prg_wdata_q, prg_wdata_d, chr_wdata_q, chr_wdata_d;
  logic            prg_ovr_q, prg_ovr_d, chr_ovr_q, chr_ovr_d;
  logic            gnt_q, gnt_d, last_q, last_d;   // 1'b0 = PRG, 1'b1 = CHR
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic [7:0]      prg_dout_q, prg_dout_d, chr_dout_q, chr_dout_d;
  logic            prg_valid_q, prg_valid_d, chr_valid_q, chr_valid_d;

  logic ack_done_s, prg_free_s, chr_free_s, prg_busy_s, chr_busy_s;
  logic prg_bus_rd_s, prg_nomem_rd_s, prg_mem_s, chr_mem_s, pick_chr_s;

  // Strobe decode; a slot completing this cycle counts as free so an ack-cycle strobe is accepted
  always_comb begin
    ack_done_s     = (state_q == BUSY) & mem_ack;
    prg_free_s     = ack_done_s & ~gnt_q;
    chr_free_s     = ack_done_s & gnt_q;
    prg_busy_s     = prg_full_q & ~prg_free_s;
    chr_busy_s     = chr_full_q & ~chr_free_s;
    prg_bus_rd_s   = prg_read & prg_bus_write;
    prg_nomem_rd_s = prg_read & ~prg_bus_write & ~prg_allow;
    prg_mem_s      = (prg_read | prg_write) & prg_allow & ~prg_bus_write;
    chr_mem_s      = chr_read | (chr_write & chr_allow);
    pick_chr_s     = chr_full_q & (~prg_full_q | ~last_q);
  end

  // Slot loading and sticky overrun flags
  always_comb begin
    prg_full_d  = prg_busy_s;
    prg_we_d    = prg_we_q;
    prg_addr_d  = prg_addr_q;
    prg_wdata_d = prg_wdata_q;
    prg_ovr_d   = prg_ovr_q;
    chr_full_d  = chr_busy_s;
    chr_we_d    = chr_we_q;
    chr_addr_d  = chr_addr_q;
    chr_wdata_d = chr_wdata_q;
    chr_ovr_d   = chr_ovr_q;
    if (prg_mem_s && prg_busy_s) begin
      prg_ovr_d = 1'b1;
    end else if (prg_mem_s) begin
      prg_full_d  = 1'b1;
      prg_we_d    = prg_write & ~prg_read;
      prg_addr_d  = prg_aout;
      prg_wdata_d = prg_din;
    end else begin
      prg_ovr_d = prg_ovr_q;
    end
    if (chr_mem_s && chr_busy_s) begin
      chr_ovr_d = 1'b1;
    end else if (chr_mem_s) begin
      chr_full_d  = 1'b1;
      chr_we_d    = chr_write & ~chr_read;
      chr_addr_d  = chr_aout;
      chr_wdata_d = chr_din;
    end else begin
      chr_ovr_d = chr_ovr_q;
    end
  end

  // Request FSM: grant from IDLE, hold the memory command in BUSY until acknowledged
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (prg_full_q || chr_full_q) begin
          state_d     = BUSY;
          gnt_d       = pick_chr_s;
          last_d      = pick_chr_s;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_chr_s ? chr_we_q : prg_we_q;
          mem_addr_d  = pick_chr_s ? chr_addr_q : prg_addr_q;
          mem_wdata_d = pick_chr_s ? chr_wdata_q : prg_wdata_q;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Read data return and one-cycle valid pulses
  always_comb begin
    prg_dout_d  = prg_dout_q;
    chr_dout_d  = chr_dout_q;
    prg_valid_d = 1'b0;
    chr_valid_d = 1'b0;
    if (prg_free_s && !prg_we_q) begin
      prg_valid_d = 1'b1;
      prg_dout_d  = mem_rdata;
    end else if (prg_bus_rd_s) begin
      prg_valid_d = 1'b1;
      prg_dout_d  = prg_mapper_dout;
    end else if (prg_nomem_rd_s) begin
      prg_valid_d = 1'b1;
    end else begin
      prg_valid_d = 1'b0;
    end
    if (chr_free_s && !chr_we_q) begin
      chr_valid_d = 1'b1;
      chr_dout_d  = mem_rdata;
    end else begin
      chr_valid_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prg_full_q  <= 1'b0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= {AW{1'b0}};
      prg_wdata_q <= 8'h00;
      prg_ovr_q   <= 1'b0;
      chr_full_q  <= 1'b0;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= {AW{1'b0}};
      chr_wdata_q <= 8'h00;
      chr_ovr_q   <= 1'b0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= 8'h00;
      prg_dout_q  <= 8'h00;
      chr_dout_q  <= 8'h00;
      prg_valid_q <= 1'b0;
      chr_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prg_full_q  <= prg_full_d;
      prg_we_q    <= prg_we_d;
      prg_addr_q  <= prg_addr_d;
      prg_wdata_q <= prg_wdata_d;
      prg_ovr_q   <= prg_ovr_d;
      chr_full_q  <= chr_full_d;
      chr_we_q    <= chr_we_d;
      chr_addr_q  <= chr_addr_d;
      chr_wdata_q <= chr_wdata_d;
      chr_ovr_q   <= chr_ovr_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      prg_dout_q  <= prg_dout_d;
      chr_dout_q  <= chr_dout_d;
      prg_valid_q <= prg_valid_d;
      chr_valid_q <= chr_valid_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign prg_dout    = prg_dout_q;
  assign chr_dout    = chr_dout_q;
  assign prg_valid   = prg_valid_q;
  assign chr_valid   = chr_valid_q;
  assign prg_overrun = prg_ovr_q;
  assign chr_overrun = chr_ovr_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: a transaction-level model predicts memory requests
// and read returns; a negedge monitor compares whatever the DUT presents.
module tb_cart_mem_arbiter;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prg_read, prg_write, prg_allow, prg_bus_write;
  logic [AW-1:0] prg_aout;
  logic [7:0]    prg_din, prg_mapper_dout;
  logic          chr_read, chr_write, chr_allow;
  logic [AW-1:0] chr_aout;
  logic [7:0]    chr_din;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [7:0]    prg_dout, chr_dout;
  logic          prg_valid, chr_valid, prg_overrun, chr_overrun;

  cart_mem_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .prg_read(prg_read), .prg_write(prg_write), .prg_aout(prg_aout), .prg_din(prg_din),
    .prg_allow(prg_allow), .prg_bus_write(prg_bus_write), .prg_mapper_dout(prg_mapper_dout),
    .chr_read(chr_read), .chr_write(chr_write), .chr_aout(chr_aout), .chr_din(chr_din),
    .chr_allow(chr_allow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .prg_dout(prg_dout), .chr_dout(chr_dout), .prg_valid(prg_valid), .chr_valid(chr_valid),
    .prg_overrun(prg_overrun), .chr_overrun(chr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } req_t;

  req_t       exp_req_q[$];
  logic [7:0] exp_prg_q[$];
  logic [7:0] exp_chr_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: index 0 = PRG slot, 1 = CHR slot
  bit         m_full[2];
  req_t       m_req[2];
  bit         m_busy;
  int         m_gnt, m_last;
  bit         m_ovr[2];
  logic [7:0] m_pdout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Predict the effect of the currently driven inputs at the coming rising edge.
  task automatic model_edge();
    int g;
    // A mapper/disallowed PRG read may not coincide with a PRG memory read completing.
    if (m_busy && m_gnt == 0 && !m_req[0].we && prg_read && (prg_bus_write || !prg_allow))
      mem_ack = 1'b0;
    if (m_busy) begin
      if (mem_ack) begin
        g = m_gnt;
        m_busy = 1'b0;
        m_full[g] = 1'b0;
        if (!m_req[g].we) begin
          if (g == 0) begin m_pdout = mem_rdata; exp_prg_q.push_back(mem_rdata); end
          else exp_chr_q.push_back(mem_rdata);
        end
      end
    end else if (m_full[0] || m_full[1]) begin
      if (m_full[0] && m_full[1]) g = 1 - m_last;
      else g = m_full[1] ? 1 : 0;
      m_busy = 1'b1; m_gnt = g; m_last = g;
      exp_req_q.push_back(m_req[g]);
    end
    if (prg_read && prg_bus_write) begin
      m_pdout = prg_mapper_dout;
      exp_prg_q.push_back(prg_mapper_dout);
    end else if (prg_read && !prg_allow) begin
      exp_prg_q.push_back(m_pdout);
    end else if ((prg_read || prg_write) && prg_allow && !prg_bus_write) begin
      if (m_full[0]) m_ovr[0] = 1'b1;
      else begin m_full[0] = 1'b1; m_req[0] = {prg_write, prg_aout, prg_din}; end
    end
    if (chr_read || (chr_write && chr_allow)) begin
      if (m_full[1]) m_ovr[1] = 1'b1;
      else begin m_full[1] = 1'b1; m_req[1] = {chr_write, chr_aout, chr_din}; end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    prg_read = 1'b0; prg_write = 1'b0; chr_read = 1'b0; chr_write = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    prg_read = 1'b0; prg_write = 1'b0; chr_read = 1'b0; chr_write = 1'b0; mem_ack = 1'b0;
    prg_allow = 1'b1; prg_bus_write = 1'b0; chr_allow = 1'b1;
    m_full = '{1'b0, 1'b0}; m_ovr = '{1'b0, 1'b0}; m_busy = 1'b0; m_gnt = 0; m_last = 0;
    m_pdout = 8'h00;
    exp_req_q.delete(); exp_prg_q.delete(); exp_chr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata},  32'd0);
    check("reset_douts",   {16'd0, prg_dout, chr_dout},              32'd0);
    check("reset_flags",   {28'd0, prg_valid, chr_valid, prg_overrun, chr_overrun}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic prg_rd(input logic [AW-1:0] a);
    prg_read = 1'b1; prg_aout = a;
  endtask

  // Monitor: compare every presented request and read return against the scoreboard
  req_t cur;
  bit   prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        check("mem_req_expected", {31'd0, exp_req_q.size() != 0}, 32'd1);
        if (exp_req_q.size() != 0) cur = exp_req_q.pop_front();
      end
      if (mem_req) check("mem_req_fields", {1'b0, mem_we, mem_addr, mem_wdata}, {1'b0, cur});
      prev_req = mem_req;
      if (prg_valid) begin
        check("prg_valid_expected", {31'd0, exp_prg_q.size() != 0}, 32'd1);
        if (exp_prg_q.size() != 0) check("prg_dout", {24'd0, prg_dout}, {24'd0, exp_prg_q.pop_front()});
      end
      if (chr_valid) begin
        check("chr_valid_expected", {31'd0, exp_chr_q.size() != 0}, 32'd1);
        if (exp_chr_q.size() != 0) check("chr_dout", {24'd0, chr_dout}, {24'd0, exp_chr_q.pop_front()});
      end
    end
  end

  initial begin
    prg_aout = '0; prg_din = 8'h00; prg_mapper_dout = 8'h00;
    chr_aout = '0; chr_din = 8'h00; mem_rdata = 8'h00;
    do_reset();

    // Basic read: request one cycle after slot load, data/valid one cycle after ack
    prg_rd(22'h008000); tick(); tick();
    check("r033_req",  {31'd0, mem_req}, 32'd1);
    check("r033_addr", {10'd0, mem_addr}, 32'h008000);
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 8'hA5; tick();
    check("r033_valid", {31'd0, prg_valid}, 32'd1);
    check("r033_dout",  {24'd0, prg_dout}, 32'h0000_00A5);
    check("r033_req_drop", {31'd0, mem_req}, 32'd0);

    // Round-robin ties, with a CHR strobe accepted in its own ack cycle
    do_reset();
    prg_rd(22'h001111); chr_read = 1'b1; chr_aout = 22'h002222; tick(); tick();
    check("r034_first_chr", {10'd0, mem_addr}, 32'h002222);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h11; chr_read = 1'b1; chr_aout = 22'h003333; tick();
    check("r034_idle_gap", {31'd0, mem_req}, 32'd0);
    tick();
    check("r034_then_prg", {10'd0, mem_addr}, 32'h001111);
    mem_ack = 1'b1; mem_rdata = 8'h22; tick(); tick();
    check("r034_chr_again", {10'd0, mem_addr}, 32'h003333);
    mem_ack = 1'b1; mem_rdata = 8'h33; tick();
    check("r034_no_overrun", {30'd0, prg_overrun, chr_overrun}, 32'd0);

    // Mapper-driven read bypasses memory
    prg_bus_write = 1'b1; prg_mapper_dout = 8'h3C; prg_rd(22'h00ABCD); tick();
    check("r035_valid", {31'd0, prg_valid}, 32'd1);
    check("r035_dout",  {24'd0, prg_dout}, 32'h0000_003C);
    check("r035_no_req", {31'd0, mem_req}, 32'd0);
    prg_bus_write = 1'b0;

    // CHR writes gated by chr_allow
    chr_write = 1'b1; chr_allow = 1'b0; chr_aout = 22'h000777; chr_din = 8'h99; tick(); tick();
    check("r036_blocked", {31'd0, mem_req}, 32'd0);
    chr_write = 1'b1; chr_allow = 1'b1; chr_aout = 22'h200010; chr_din = 8'h5A; tick(); tick();
    check("r036_write", {mem_req, mem_we, 6'd0, mem_wdata, 16'd0}, {1'b1, 1'b1, 6'd0, 8'h5A, 16'd0});
    mem_ack = 1'b1; tick();

    // Ack-cycle strobe accepted, then an in-flight strobe dropped
    do_reset();
    prg_rd(22'h000100); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 8'h44; prg_rd(22'h000300); tick();
    check("r037_ack_accept", {31'd0, prg_overrun}, 32'd0);
    tick();
    check("r037_second_req", {10'd0, mem_addr}, 32'h000300);
    mem_ack = 1'b1; mem_rdata = 8'h55; tick();
    prg_rd(22'h000400); tick(); tick();
    prg_rd(22'h000500); tick();
    check("r037_overrun", {31'd0, prg_overrun}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h66; tick(); tick(); tick();
    check("r037_single_access", {31'd0, mem_req}, 32'd0);

    // Reset during BUSY, then a late ack while IDLE
    prg_rd(22'h000600); tick(); tick();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 8'h77; tick();
    check("r038_no_valid", {30'd0, prg_valid, chr_valid}, 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        if ($urandom_range(0, 1) == 0) prg_read = 1'b1; else prg_write = 1'b1;
        prg_aout = AW'($urandom); prg_din = 8'($urandom); prg_mapper_dout = 8'($urandom);
        prg_allow = ($urandom_range(0, 7) != 0);
        prg_bus_write = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 99) < 30) begin
        if ($urandom_range(0, 1) == 0) chr_read = 1'b1; else chr_write = 1'b1;
        chr_aout = AW'($urandom); chr_din = 8'($urandom);
        chr_allow = ($urandom_range(0, 3) != 0);
      end
      mem_ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata = 8'($urandom);
      tick();
    end

    // Drain outstanding work with a bounded loop
    for (int i = 0; i < 50 && (m_busy || m_full[0] || m_full[1]); i++) begin
      mem_ack = m_busy; mem_rdata = 8'($urandom); tick();
    end
    tick(); tick();
    check("drain_done", {29'd0, m_busy, m_full[0], m_full[1]}, 32'd0);
    check("req_queue_empty", exp_req_q.size(), 32'd0);
    check("prg_queue_empty", exp_prg_q.size(), 32'd0);
    check("chr_queue_empty", exp_chr_q.size(), 32'd0);
    check("rand_prg_overrun", {31'd0, prg_overrun}, {31'd0, m_ovr[0]});
    check("rand_chr_overrun", {31'd0, chr_overrun}, {31'd0, m_ovr[1]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
